// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator-side bridge between the execute stage and the data memory port.
// Takes one RV32I load or store per request handshake, drives the memory
// with a byte-lane write enable / read enable for WAIT_STATES+1 cycles, and
// returns sign- or zero-extended load data. Misaligned or illegal requests
// are answered straight away with a flag and never reach the memory.
//
// Parameters
//   WAIT_STATES       extra memory cycles before write commit / read capture (0..15)
// Ports
//   i_clk, i_rst_n    rising-edge clock, asynchronous active-low reset
//   i_req_*           request handshake: valid/ready, we, funct3, byte addr, store data
//   o_rsp_*           response handshake: valid/ready, load data, misaligned, illegal
//   o_mem_addr/wd     byte address and lane-replicated write data to memory
//   o_mem_wen/ren     4-bit byte-write enable and read enable
//   i_mem_rd          combinational read word from memory
module load_store_unit #(
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_misaligned,
  output logic        o_rsp_illegal,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t      state;
  state_t      state_next;

  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  wait_cnt;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_illegal;

  logic        in_illegal;
  logic        in_misaligned;
  logic        in_fault;
  logic        last_access;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [3:0]  store_mask;
  logic [31:0] store_data;

  // Classify the incoming request. Loads accept the unsigned codes, stores
  // do not. Illegal wins over misaligned so only one flag is ever raised.
  always_comb begin
    in_illegal    = 1'b0;
    in_misaligned = 1'b0;
    case (i_req_funct3)
      3'b000:          in_illegal = 1'b0;
      3'b001:          in_misaligned = i_req_addr[0];
      3'b010:          in_misaligned = (i_req_addr[1:0] != 2'b00);
      3'b100:          in_illegal = i_req_we;
      3'b101: begin
        in_illegal    = i_req_we;
        in_misaligned = i_req_addr[0];
      end
      default:         in_illegal = 1'b1;
    endcase
    if (in_illegal) begin
      in_misaligned = 1'b0;
    end
    in_fault = in_illegal | in_misaligned;
  end

  assign last_access = (state == ACCESS) && (wait_cnt == WAIT_LAST);

  // Pick the addressed lane out of the memory word and extend it.
  always_comb begin
    case (req_addr[1:0])
      2'd0:    load_byte = i_mem_rd[7:0];
      2'd1:    load_byte = i_mem_rd[15:8];
      2'd2:    load_byte = i_mem_rd[23:16];
      default: load_byte = i_mem_rd[31:24];
    endcase
    load_half = req_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
    case (req_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      3'b010:  load_data = i_mem_rd;
      default: load_data = 32'd0;
    endcase
  end

  // Store lanes: data is replicated across the word so both lane-indexed
  // and low-bit-truncating memories see the right bytes.
  always_comb begin
    case (req_funct3)
      3'b000: begin
        store_mask = 4'b0001 << req_addr[1:0];
        store_data = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        store_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        store_mask = 4'b1111;
        store_data = req_wdata;
      end
      default: begin
        store_mask = 4'b0000;
        store_data = 32'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all handshake / memory outputs. Memory outputs are decoded
  // from the state so that reset silences them without waiting for a clock.
  always_comb begin
    state_next  = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wd    = 32'd0;
    o_mem_wen   = 4'b0000;
    o_mem_ren   = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_next = in_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        o_mem_addr = req_addr;
        o_mem_ren  = ~req_we;
        if (req_we) begin
          o_mem_wd = store_data;
        end
        if (last_access) begin
          state_next = RESP;
          if (req_we) begin
            o_mem_wen = store_mask;
          end
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_we         <= 1'b0;
      req_funct3     <= 3'd0;
      req_addr       <= 32'd0;
      req_wdata      <= 32'd0;
      wait_cnt       <= 4'd0;
      rsp_rdata      <= 32'd0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_we         <= i_req_we;
            req_funct3     <= i_req_funct3;
            req_addr       <= i_req_addr;
            req_wdata      <= i_req_wdata;
            wait_cnt       <= 4'd0;
            rsp_rdata      <= 32'd0;
            rsp_misaligned <= in_misaligned;
            rsp_illegal    <= in_illegal;
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (last_access && !req_we) begin
            rsp_rdata <= load_data;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_rdata      <= 32'd0;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_rdata      = rsp_rdata;
  assign o_rsp_misaligned = rsp_misaligned;
  assign o_rsp_illegal    = rsp_illegal;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives two load_store_unit instances (WAIT_STATES=0 and WAIT_STATES=3)
// through a shared request bus, each backed by a small byte-enable memory.
// Expected responses are queued when a request is driven and popped when
// the unit answers; memory-side activity is checked per transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  bit          sel;

  logic        req_ready_0, rsp_valid_0, mis_0, ill_0, mren_0;
  logic        req_ready_1, rsp_valid_1, mis_1, ill_1, mren_1;
  logic [31:0] rdata_0, maddr_0, mwd_0, mrd_0;
  logic [31:0] rdata_1, maddr_1, mwd_1, mrd_1;
  logic [3:0]  mwen_0, mwen_1;

  logic        v_req_ready, v_rsp_valid, v_mis, v_ill, v_mren;
  logic [31:0] v_rdata, v_maddr, v_mwd;
  logic [3:0]  v_mwen;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic        pre_en;
  bit          pre_sel;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  typedef struct {
    bit          sel;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_ill;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid && !sel), .o_req_ready(req_ready_0),
    .i_req_we(req_we), .i_req_funct3(req_funct3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_0), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rdata_0), .o_rsp_misaligned(mis_0), .o_rsp_illegal(ill_0),
    .o_mem_addr(maddr_0), .o_mem_wd(mwd_0), .o_mem_wen(mwen_0),
    .o_mem_ren(mren_0), .i_mem_rd(mrd_0)
  );

  load_store_unit #(.WAIT_STATES(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid && sel), .o_req_ready(req_ready_1),
    .i_req_we(req_we), .i_req_funct3(req_funct3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_1), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rdata_1), .o_rsp_misaligned(mis_1), .o_rsp_illegal(ill_1),
    .o_mem_addr(maddr_1), .o_mem_wd(mwd_1), .o_mem_wen(mwen_1),
    .o_mem_ren(mren_1), .i_mem_rd(mrd_1)
  );

  assign v_req_ready = sel ? req_ready_1 : req_ready_0;
  assign v_rsp_valid = sel ? rsp_valid_1 : rsp_valid_0;
  assign v_rdata     = sel ? rdata_1     : rdata_0;
  assign v_mis       = sel ? mis_1       : mis_0;
  assign v_ill       = sel ? ill_1       : ill_0;
  assign v_maddr     = sel ? maddr_1     : maddr_0;
  assign v_mwd       = sel ? mwd_1       : mwd_0;
  assign v_mwen      = sel ? mwen_1      : mwen_0;
  assign v_mren      = sel ? mren_1      : mren_0;

  assign mrd_0 = mem0[maddr_0[9:2]];
  assign mrd_1 = mem1[maddr_1[9:2]];

  // Word memories with byte-write enables, plus a preload path for setup.
  always @(posedge clk) begin
    if (pre_en && !pre_sel) mem0[pre_idx] <= pre_data;
    if (pre_en && pre_sel)  mem1[pre_idx] <= pre_data;
    for (int b = 0; b < 4; b++) begin
      if (mwen_0[b]) mem0[maddr_0[9:2]][8*b +: 8] <= mwd_0[8*b +: 8];
      if (mwen_1[b]) mem1[maddr_1[9:2]][8*b +: 8] <= mwd_1[8*b +: 8];
    end
  end

  function automatic vec_t mk(bit s, logic we, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic mis,
                              logic ill, logic [3:0] wen, logic [31:0] ewd);
    vec_t v;
    v.sel = s; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = rd; v.exp_mis = mis; v.exp_ill = ill;
    v.exp_wen = wen; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the visible response against the oldest queued expectation.
  task automatic checkResponse(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb_q.pop_front();
      checkOutput({name, " rdata"}, v_rdata, e.rdata);
      checkOutput({name, " misaligned"}, 32'(v_mis), 32'(e.mis));
      checkOutput({name, " illegal"}, 32'(v_ill), 32'(e.ill));
    end
  endtask

  task automatic preload(input bit s, input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_sel = s; pre_idx = idx; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One complete transaction with i_rsp_ready held high.
  task automatic applyStimulus(input int n, input vec_t v);
    int   ws = v.sel ? 3 : 0;
    bit   fault = v.exp_mis | v.exp_ill;
    int   e = 0;
    int   wen_n = 0, ren_n = 0, wen_off = -1;
    logic [3:0]  wen_v = 4'd0;
    logic [31:0] wd_v = 32'd0, addr_v = 32'd0;
    bit   got = 0;
    string nm = $sformatf("vec%0d", n);
    @(negedge clk);
    sel = v.sel;
    checkOutput({nm, " req_ready"}, 32'(v_req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b1;
    sb_q.push_back('{v.exp_rdata, v.exp_mis, v.exp_ill});
    while (!got && e < 40) begin
      @(posedge clk); #1;
      e++;
      if (e == 1) req_valid = 1'b0;
      if (v_mwen != 4'd0) begin
        wen_n++; wen_v = v_mwen; wd_v = v_mwd; wen_off = e - 1; addr_v = v_maddr;
      end
      if (v_mren) begin
        ren_n++; addr_v = v_maddr;
      end
      if (v_rsp_valid) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no response expected response", nm);
      void'(sb_q.pop_front());
    end else begin
      checkOutput({nm, " latency"}, 32'(e), fault ? 32'd1 : 32'(ws + 2));
      checkResponse(nm);
      checkOutput({nm, " wen_count"}, 32'(wen_n), (v.exp_wen != 0) ? 32'd1 : 32'd0);
      if (v.exp_wen != 0) begin
        checkOutput({nm, " wen"}, 32'(wen_v), 32'(v.exp_wen));
        checkOutput({nm, " wd"}, wd_v, v.exp_wd);
        checkOutput({nm, " wen_cycle"}, 32'(wen_off), 32'(ws));
        checkOutput({nm, " addr"}, addr_v, v.addr);
      end
      checkOutput({nm, " ren_count"}, 32'(ren_n),
                  (!v.we && !fault) ? 32'(ws + 1) : 32'd0);
      if (!v.we && !fault) checkOutput({nm, " ren_addr"}, addr_v, v.addr);
      @(posedge clk); #1;
      checkOutput({nm, " valid_after"}, 32'(v_rsp_valid), 32'd0);
      checkOutput({nm, " ready_after"}, 32'(v_req_ready), 32'd1);
      checkOutput({nm, " rdata_after"}, v_rdata, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1; sel = 0;
    pre_en = 1'b0; pre_sel = 0; pre_idx = 8'd0; pre_data = 32'd0;

    // Reset values seen from both instances.
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      checkOutput("reset req_ready", 32'(v_req_ready), 32'd1);
      checkOutput("reset rsp_valid", 32'(v_rsp_valid), 32'd0);
      checkOutput("reset rdata", v_rdata, 32'd0);
      checkOutput("reset flags", 32'({v_mis, v_ill}), 32'd0);
      checkOutput("reset mem", 32'({v_mwen, v_mren}), 32'd0);
      checkOutput("reset mem_addr", v_maddr | v_mwd, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    preload(0, 8'h40, 32'h80FF7F01);
    preload(0, 8'h80, 32'h00000000);
    preload(1, 8'h10, 32'h00000000);

    vecs.push_back(mk(0, 0, 3'b000, 32'h101, 0, 32'h0000007F, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h102, 0, 32'hFFFFFFFF, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b100, 32'h102, 0, 32'h000000FF, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h102, 0, 32'hFFFF80FF, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h102, 0, 32'h000080FF, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h100, 0, 32'h80FF7F01, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h103, 0, 32'hFFFFFF80, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h100, 0, 32'h00007F01, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 4'b1000, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0, 3'b010, 32'h100, 0, 32'hA5FF7F01, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 0, 4'b1100, 32'hBEEFBEEF));
    vecs.push_back(mk(0, 1, 3'b001, 32'h200, 32'h00001357, 0, 0, 0, 4'b0011, 32'h13571357));
    vecs.push_back(mk(0, 0, 3'b010, 32'h200, 0, 32'hBEEF1357, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h201, 32'h0000003C, 0, 0, 0, 4'b0010, 32'h3C3C3C3C));
    vecs.push_back(mk(0, 0, 3'b100, 32'h201, 0, 32'h0000003C, 0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h201, 32'h00001111, 0, 1, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h202, 0, 0, 1, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h100, 32'h000000FF, 0, 0, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b011, 32'h100, 0, 0, 0, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h103, 0, 0, 1, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 3'b101, 32'h201, 0, 0, 0, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 32'h100, 0, 0, 0, 1, 4'h0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h040, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h040, 0, 32'hDEADBEEF, 0, 0, 4'h0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h042, 0, 32'hFFFFDEAD, 0, 0, 4'h0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h041, 32'h12345678, 0, 1, 0, 4'h0, 0));

    foreach (vecs[i]) applyStimulus(i, vecs[i]);
    checkOutput("mem0 0x200 final", mem0[8'h80], 32'hBEEF3C57);
    checkOutput("mem1 0x40 final", mem1[8'h10], 32'hDEADBEEF);

    // Response held off: outputs stay put and a new request waits.
    @(negedge clk);
    sel = 0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    sb_q.push_back('{32'hA5FF7F01, 1'b0, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold valid", 32'(v_rsp_valid), 32'd1);
    checkResponse("hold first");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b111; req_addr = 32'h300;
    sb_q.push_back('{32'd0, 1'b0, 1'b1});
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d valid", h), 32'(v_rsp_valid), 32'd1);
      checkOutput($sformatf("hold%0d rdata", h), v_rdata, 32'hA5FF7F01);
      checkOutput($sformatf("hold%0d ready", h), 32'(v_req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold release valid", 32'(v_rsp_valid), 32'd0);
    checkOutput("hold release ready", 32'(v_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("second valid", 32'(v_rsp_valid), 32'd1);
    checkResponse("second");
    @(posedge clk); #1;
    checkOutput("second done", 32'(v_rsp_valid), 32'd0);

    // Reset during the final write cycle of a 4-cycle store.
    preload(1, 8'h10, 32'h11111111);
    @(negedge clk);
    sel = 1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) @(posedge clk);
    #1;
    checkOutput("rst pre wen", 32'(v_mwen), 32'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst wen", 32'(v_mwen), 32'd0);
    checkOutput("rst valid", 32'(v_rsp_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("rst hold valid", 32'(v_rsp_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("post rst valid", 32'(v_rsp_valid), 32'd0);
    end
    checkOutput("post rst ready", 32'(v_req_ready), 32'd1);
    checkOutput("post rst mem", mem1[8'h10], 32'h11111111);

    // Reset while a load response is waiting.
    @(negedge clk);
    sel = 0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("resp rst pre", 32'(v_rsp_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("resp rst valid", 32'(v_rsp_valid), 32'd0);
    checkOutput("resp rst rdata", v_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    checkOutput("resp rst ready", 32'(v_req_ready), 32'd1);

    checkOutput("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
